// File: rtl/alu_result_scoreboard.sv
// In-order scoreboard: expected ALU results are queued and compared against each
// result announced by a rising edge of i_alu_res_valid. Optional macro ALU_SB_FIRST_FAIL_EN.
module alu_result_scoreboard #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_exp_valid,
  input  logic [DATA_W-1:0]          i_exp_result,
  output logic                       o_exp_ready,
  input  logic                       i_alu_res_valid,
  input  logic [DATA_W-1:0]          i_alu_result,
  output logic [$clog2(DEPTH):0]     o_pending,
  output logic [CNT_W-1:0]           o_pass_cnt,
  output logic [CNT_W-1:0]           o_fail_cnt,
  output logic                       o_match,
  output logic                       o_mismatch,
  output logic                       o_overflow,
  output logic                       o_underflow,
  output logic                       o_idle,
  output logic [DATA_W-1:0]          o_ff_exp,
  output logic [DATA_W-1:0]          o_ff_act,
  output logic [CNT_W-1:0]           o_ff_idx
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              rv_q;

  logic              res_evt_c;
  logic              push_c;
  logic              pop_c;
  logic              hit_c;
  logic [OCC_W-1:0]  occ_nxt_c;

  // A result is signalled only by a low-to-high transition of the valid level.
  assign res_evt_c = i_alu_res_valid & ~rv_q;
  assign push_c    = i_exp_valid & o_exp_ready;
  assign pop_c     = res_evt_c & (o_pending != '0);
  assign hit_c     = (mem[rd_ptr] == i_alu_result);

  always_comb begin
    occ_nxt_c = o_pending;
    if (push_c && !pop_c)      occ_nxt_c = o_pending + OCC_W'(1);
    else if (pop_c && !push_c) occ_nxt_c = o_pending - OCC_W'(1);
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge i_clk) begin
    if (push_c) mem[wr_ptr] <= i_exp_result;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rv_q        <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_pending   <= '0;
      o_exp_ready <= 1'b1;
      o_idle      <= 1'b1;
      o_pass_cnt  <= '0;
      o_fail_cnt  <= '0;
      o_match     <= 1'b0;
      o_mismatch  <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      rv_q        <= i_alu_res_valid;
      o_pending   <= occ_nxt_c;
      o_exp_ready <= (occ_nxt_c < OCC_W'(DEPTH));
      o_idle      <= (occ_nxt_c == '0);
      o_match     <= pop_c & hit_c;
      o_mismatch  <= pop_c & ~hit_c;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (i_exp_valid && !o_exp_ready)       o_overflow  <= 1'b1;
      if (res_evt_c && (o_pending == '0))    o_underflow <= 1'b1;
      // Counters saturate rather than wrap.
      if (pop_c && hit_c && (o_pass_cnt != CNT_MAX))  o_pass_cnt <= o_pass_cnt + CNT_W'(1);
      if (pop_c && !hit_c && (o_fail_cnt != CNT_MAX)) o_fail_cnt <= o_fail_cnt + CNT_W'(1);
    end
  end

`ifdef ALU_SB_FIRST_FAIL_EN
  logic ff_seen;

  // Capture only the first mismatch after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ff_seen  <= 1'b0;
      o_ff_exp <= '0;
      o_ff_act <= '0;
      o_ff_idx <= '0;
    end else if (pop_c && !hit_c && !ff_seen) begin
      ff_seen  <= 1'b1;
      o_ff_exp <= mem[rd_ptr];
      o_ff_act <= i_alu_result;
      o_ff_idx <= CNT_W'(o_pass_cnt + o_fail_cnt);
    end
  end
`else
  assign o_ff_exp = '0;
  assign o_ff_act = '0;
  assign o_ff_idx = '0;
`endif

endmodule

// File: tb/tb_alu_result_scoreboard.sv
// Randomized and directed bench for alu_result_scoreboard against a queue-based reference model.
module tb_alu_result_scoreboard;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              exp_valid = 1'b0;
  logic [DATA_W-1:0] exp_result = '0;
  logic              exp_ready;
  logic              alu_res_valid = 1'b1;
  logic [DATA_W-1:0] alu_result = '0;
  logic [$clog2(DEPTH):0] pending;
  logic [CNT_W-1:0]  pass_cnt, fail_cnt, ff_idx;
  logic              match, mismatch, overflow, underflow, idle;
  logic [DATA_W-1:0] ff_exp, ff_act;

  alu_result_scoreboard #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_exp_valid(exp_valid), .i_exp_result(exp_result), .o_exp_ready(exp_ready),
    .i_alu_res_valid(alu_res_valid), .i_alu_result(alu_result),
    .o_pending(pending), .o_pass_cnt(pass_cnt), .o_fail_cnt(fail_cnt),
    .o_match(match), .o_mismatch(mismatch), .o_overflow(overflow),
    .o_underflow(underflow), .o_idle(idle),
    .o_ff_exp(ff_exp), .o_ff_act(ff_act), .o_ff_idx(ff_idx)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int   m_pass, m_fail;
  bit   m_prev, m_ready, m_match, m_mismatch, m_ovf, m_udf;
  bit   m_ff_seen;
  logic [DATA_W-1:0] m_ff_exp, m_ff_act;
  int   m_ff_idx;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit evt, accept;
    logic [DATA_W-1:0] head;
    if (!rst_n) begin
      q.delete();
      m_pass = 0; m_fail = 0; m_prev = 1; m_ready = 1;
      m_match = 0; m_mismatch = 0; m_ovf = 0; m_udf = 0;
      m_ff_seen = 0; m_ff_exp = '0; m_ff_act = '0; m_ff_idx = 0;
      return;
    end
    evt    = alu_res_valid && !m_prev;
    m_prev = alu_res_valid;
    m_match = 0; m_mismatch = 0;
    accept = exp_valid && m_ready;
    if (exp_valid && !m_ready) m_ovf = 1;
    if (evt) begin
      if (q.size() == 0) m_udf = 1;
      else begin
        head = q.pop_front();
        if (head == alu_result) begin
          m_match = 1;
          if (m_pass < CNT_MAX) m_pass++;
        end else begin
          m_mismatch = 1;
          if (!m_ff_seen) begin
            m_ff_seen = 1; m_ff_exp = head; m_ff_act = alu_result;
            m_ff_idx = m_pass + m_fail;
          end
          if (m_fail < CNT_MAX) m_fail++;
        end
      end
    end
    if (accept) q.push_back(exp_result);
    m_ready = q.size() < DEPTH;
  endtask

  task automatic check_all();
    chk("pending",   64'(pending),   64'(q.size()));
    chk("exp_ready", 64'(exp_ready), 64'(m_ready));
    chk("idle",      64'(idle),      64'(q.size() == 0));
    chk("pass_cnt",  64'(pass_cnt),  64'(m_pass));
    chk("fail_cnt",  64'(fail_cnt),  64'(m_fail));
    chk("match",     64'(match),     64'(m_match));
    chk("mismatch",  64'(mismatch),  64'(m_mismatch));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("underflow", 64'(underflow), 64'(m_udf));
`ifdef ALU_SB_FIRST_FAIL_EN
    chk("ff_exp", 64'(ff_exp), 64'(m_ff_exp));
    chk("ff_act", 64'(ff_act), 64'(m_ff_act));
    chk("ff_idx", 64'(ff_idx), 64'(m_ff_idx));
`else
    chk("ff_exp_tied", 64'(ff_exp), 64'(0));
    chk("ff_act_tied", 64'(ff_act), 64'(0));
    chk("ff_idx_tied", 64'(ff_idx), 64'(0));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0; exp_valid = 0; alu_res_valid = 0;
    step();
    rst_n = 1;
    step();
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    exp_valid = 1; exp_result = v;
    step();
    exp_valid = 0;
  endtask

  task automatic result(input logic [DATA_W-1:0] v);
    alu_res_valid = 1; alu_result = v;
    step();
    alu_res_valid = 0;
    step();
  endtask

  initial begin
    // Valid held high through reset must not register as a result
    rst_n = 0; alu_res_valid = 1;
    step(); step();
    rst_n = 1;
    step(); step(); step();
    chk("tp1_underflow", 64'(underflow), 64'(0));
    chk("tp1_pass",      64'(pass_cnt),  64'(0));
    chk("tp1_idle",      64'(idle),      64'(1));
    alu_res_valid = 0;
    step();

    // Single match with a 3-cycle valid level
    push(32'h5);
    step(); step();
    alu_res_valid = 1; alu_result = 32'h5;
    step(); step(); step();
    alu_res_valid = 0;
    step();
    chk("tp2_pass",    64'(pass_cnt), 64'(1));
    chk("tp2_pending", 64'(pending),  64'(0));

    // One pass then one fail
    do_reset();
    push(32'hDEADBEEF);
    push(32'h10);
    result(32'hDEADBEEF);
    result(32'h11);
    chk("tp3_pass", 64'(pass_cnt), 64'(1));
    chk("tp3_fail", 64'(fail_cnt), 64'(1));
`ifdef ALU_SB_FIRST_FAIL_EN
    chk("tp3_ff_exp", 64'(ff_exp), 64'h10);
    chk("tp3_ff_act", 64'(ff_act), 64'h11);
    chk("tp3_ff_idx", 64'(ff_idx), 64'(1));
`endif

    // Overfill
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push(32'(i + 100));
      if (i == 7) chk("tp4_ready_full", 64'(exp_ready), 64'(0));
    end
    chk("tp4_overflow", 64'(overflow), 64'(1));
    chk("tp4_pending",  64'(pending),  64'(8));

    // Result edge on empty FIFO with simultaneous push
    do_reset();
    exp_valid = 1; exp_result = 32'h77; alu_res_valid = 1; alu_result = 32'h77;
    step();
    exp_valid = 0; alu_res_valid = 0;
    step();
    chk("tp5_underflow", 64'(underflow), 64'(1));
    chk("tp5_pass",      64'(pass_cnt),  64'(0));
    chk("tp5_pending",   64'(pending),   64'(1));

    // Full FIFO under continuous pushes with results every other cycle, then reset
    do_reset();
    for (int i = 0; i < 8; i++) push(32'(i + 200));
    exp_valid = 1;
    for (int i = 0; i < 24; i++) begin
      exp_result = 32'(i + 300);
      if (i % 2 == 0 && q.size() != 0) begin
        alu_res_valid = 1; alu_result = q[0];
      end else alu_res_valid = 0;
      step();
    end
    rst_n = 0;
    step();
    rst_n = 1; exp_valid = 0; alu_res_valid = 0;
    chk("tp6_pending", 64'(pending),   64'(0));
    chk("tp6_ready",   64'(exp_ready), 64'(1));
    chk("tp6_pass",    64'(pass_cnt),  64'(0));
    chk("tp6_ovf",     64'(overflow),  64'(0));
    step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      exp_valid = ($urandom_range(0, 2) != 0);
      exp_result = $urandom();
      if (!alu_res_valid) begin
        alu_res_valid = ($urandom_range(0, 1) != 0);
        if (q.size() != 0 && $urandom_range(0, 3) != 0) alu_result = q[0];
        else alu_result = $urandom();
      end else begin
        alu_res_valid = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
